// File: rtl/corr_pkg.sv
// corr_pkg: shared constants and dump FSM states for the correlator readout path.
// With CORR_DUMP_HDR_EN defined the FSM gains three header states.
package corr_pkg;
  localparam int ADDR_W = 8;
  localparam int N_BINS = 2 ** ADDR_W;
  localparam int RD_LAT = 2;
  localparam logic [7:0] HDR_SYNC0 = 8'hA5;
  localparam logic [7:0] HDR_SYNC1 = 8'h5A;
  typedef enum logic [3:0] {
    S_IDLE,
`ifdef CORR_DUMP_HDR_EN
    S_HDR0, S_HDR1, S_HDR2,
`endif
    S_SETUP, S_ADDR, S_WAIT, S_CAP, S_SEND, S_GAP, S_CLR, S_CLRW, S_FIN
  } state_t;
endpackage

// File: rtl/corr_word_ser.sv
// corr_word_ser: splits a loaded 32-bit word into 4 bytes over a valid/ready link.
module corr_word_ser #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_valid,
  output logic        o_last_byte,
  output logic        o_word_done
);
  logic [31:0] r_sh;
  logic [1:0]  r_cnt;
  logic        r_vld;
  logic        w_hs;
  assign w_hs        = r_vld & i_ready;
  assign o_valid     = r_vld;
  assign o_last_byte = r_cnt == 2'd3;
  assign o_word_done = w_hs & o_last_byte;
  assign o_data      = LSB_FIRST ? r_sh[7:0] : r_sh[31:24];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_vld <= 1'b0;
    end else if (i_load) begin
      r_sh  <= i_word;
      r_cnt <= '0;
      r_vld <= 1'b1;
    end else if (w_hs) begin
      r_sh  <= LSB_FIRST ? {8'h00, r_sh[31:8]} : {r_sh[23:0], 8'h00};
      r_cnt <= r_cnt + 2'd1;
      r_vld <= !o_last_byte;
    end
  end
endmodule

// File: rtl/corr_dump.sv
// corr_dump: reads every bin of the correlator bank and streams it out bytewise,
// optionally clearing the bank afterwards. CORR_DUMP_HDR_EN prepends a 3-byte header.
module corr_dump
  import corr_pkg::*;
#(
  parameter bit LSB_FIRST = 1'b1,
  parameter int CLR_WAIT  = 258
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clr_after,
  input  logic              acc_busy,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              clr_req,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  localparam int WW = $clog2(CLR_WAIT);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_idx;
  logic              r_clr;
  logic [WW-1:0]     r_wait;
  logic              w_last_bin, w_word_done, w_byte3, w_ser_valid;
  logic [7:0]        w_ser_data;
`ifdef CORR_DUMP_HDR_EN
  logic [7:0]        r_seq;
  logic              w_hdr;
`endif
  assign w_last_bin = r_idx == ADDR_W'(N_BINS - 1);
  always_comb begin
    w_next = r_state;
    case (r_state)
`ifdef CORR_DUMP_HDR_EN
      S_IDLE:  w_next = (start && !acc_busy) ? S_HDR0 : S_IDLE;
      S_HDR0:  w_next = out_ready ? S_HDR1 : S_HDR0;
      S_HDR1:  w_next = out_ready ? S_HDR2 : S_HDR1;
      S_HDR2:  w_next = out_ready ? S_SETUP : S_HDR2;
`else
      S_IDLE:  w_next = (start && !acc_busy) ? S_SETUP : S_IDLE;
`endif
      S_SETUP: w_next = S_ADDR;
      S_ADDR:  w_next = S_WAIT;
      S_WAIT:  w_next = S_CAP;
      S_CAP:   w_next = S_SEND;
      S_SEND:  w_next = w_word_done ? (w_last_bin ? S_GAP : S_ADDR) : S_SEND;
      S_GAP:   w_next = r_clr ? S_CLR : S_FIN;
      S_CLR:   w_next = S_CLRW;
      S_CLRW:  w_next = (r_wait == WW'(CLR_WAIT - 1)) ? S_FIN : S_CLRW;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_clr   <= 1'b0;
      r_wait  <= '0;
`ifdef CORR_DUMP_HDR_EN
      r_seq   <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_wait  <= (r_state == S_CLRW) ? r_wait + 1'b1 : '0;
      if (r_state == S_IDLE && w_next != S_IDLE) begin
        r_idx <= '0;
        r_clr <= clr_after;
      end
      if (r_state == S_SEND && w_next == S_ADDR) r_idx <= r_idx + 1'b1;
`ifdef CORR_DUMP_HDR_EN
      if (r_state == S_FIN) r_seq <= r_seq + 8'd1;
`endif
    end
  end
  corr_word_ser #(.LSB_FIRST(LSB_FIRST)) u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (r_state == S_CAP),
    .i_word      (rd_data),
    .i_ready     (out_ready),
    .o_data      (w_ser_data),
    .o_valid     (w_ser_valid),
    .o_last_byte (w_byte3),
    .o_word_done (w_word_done)
  );
  // rd_addr follows the bin index directly, so it is held through ADDR, WAIT and CAP
  assign rd_addr  = r_idx;
  assign rd_en    = r_state inside {S_SETUP, S_ADDR, S_WAIT, S_CAP, S_SEND};
  assign busy     = r_state != S_IDLE;
  assign done     = r_state == S_FIN;
  assign clr_req  = r_state == S_CLR;
  assign out_last = w_ser_valid & w_byte3 & w_last_bin;
`ifdef CORR_DUMP_HDR_EN
  assign w_hdr     = r_state inside {S_HDR0, S_HDR1, S_HDR2};
  assign out_valid = w_hdr | w_ser_valid;
  assign out_data  = r_state == S_HDR0 ? HDR_SYNC0 :
                     r_state == S_HDR1 ? HDR_SYNC1 :
                     r_state == S_HDR2 ? r_seq : w_ser_data;
`else
  assign out_valid = w_ser_valid;
  assign out_data  = w_ser_data;
`endif
endmodule
